aes_tx_sequencer: RTL and testbench
===================================

Name: aes_tx_sequencer

Overview:
- Sequences one 128-bit AES ciphertext block into the byte-wide UART transmit path.
- Builds each frame as an optional start-of-frame byte, then 16 data bytes (MSB byte first), then an optional CRC-8 trailer.
- Paces every byte with a load/busy handshake against the UART transmitter.
- Sits between the AES core output and the UART TX; it is the only driver of the transmitter's load strobe.

Parameters:
- SOF_EN, 1, 1 = prepend SOF_BYTE to every frame; 0 = no header.
- SOF_BYTE, 8'hA5, header byte value.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- blk_valid  input  1  AES block available.
- blk_ready  output  1  sequencer can accept a block.
- blk_data  input  128  ciphertext; byte 0 = blk_data[127:120].
- crc_en  input  1  append CRC trailer; sampled only at block accept.
- tx_busy  input  1  UART transmitter busy.
- tx_data  output  8  byte presented to the UART.
- tx_load  output  1  one-cycle strobe that loads tx_data.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse when a frame completes.
- frame_cnt  output  CNT_W  completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate): state IDLE; blk_ready=0 while reset is high, then 1 in IDLE; tx_load=0, tx_data=0, busy=0, frame_done=0, frame_cnt=0, CRC register=0, byte index=0.
- A reset asserted mid-frame abandons the frame: no further tx_load, no frame_done, frame_cnt cleared.
- Block accept: blk_valid && blk_ready on edge N.
  - Latch blk_data into a shift register and latch crc_en.
  - Clear CRC to 8'h00 and set byte index=0.
  - blk_ready falls and busy rises at N+1.
- State machine:
  - IDLE -> ISSUE on accept.
  - ISSUE: if tx_busy=0, drive tx_data with the current byte and pulse tx_load for exactly one cycle, then -> GUARD. If tx_busy=1, hold in ISSUE with tx_load=0.
  - GUARD: one cycle, tx_busy ignored (covers the UART's one-cycle busy rise latency), then -> WAIT.
  - WAIT: stay while tx_busy=1. On tx_busy=0, advance the byte pointer, then go to ISSUE if bytes remain, else DONE.
  - DONE: one cycle; frame_done=1, frame_cnt+=1, busy=0 next cycle; -> IDLE.
- Byte order: SOF (if SOF_EN), then data bytes 0..15, then CRC (if latched crc_en).
- Frame length: 16, 17 or 18 bytes.
- First tx_load is at N+1 when tx_busy=0.
- Minimum spacing between consecutive tx_load pulses is 3 cycles (ISSUE, GUARD, WAIT with immediate tx_busy=0).
- CRC-8:
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR.
  - Updated with each data byte in the cycle its tx_load fires; one byte per clock, computed combinationally over 8 bits.
  - SOF and the CRC byte itself are excluded from the CRC.
- blk_ready is high only in IDLE, so no block is accepted while busy. blk_valid held high during a frame is accepted at the first IDLE cycle after DONE.
- crc_en toggling mid-frame has no effect on the current frame.
- tx_data holds its last value between loads.
- frame_cnt wraps from all-ones to 0 without any flag.

Test Plan:
- Accept all-zero block, crc_en=1, SOF_EN=1, UART busy 10 cycles per byte:
  - 18 tx_load pulses with bytes A5, 00 x16, 00.
  - One frame_done pulse; frame_cnt=1.
- Block 128'h0102...0F10, crc_en=0:
  - 17 loads with bytes A5, 01..10 in order.
  - No trailer byte; blk_ready returns to 1 one cycle after frame_done.
- Block all zeros except blk_data[7:0]=8'h01, crc_en=1:
  - 16th data byte is 01 and trailer byte is 07.
- tx_busy held high for 50 cycles at accept:
  - No tx_load until tx_busy falls, then tx_load on the next cycle.
  - tx_busy glitching high during GUARD is ignored.
- Reset asserted after the 5th data byte:
  - tx_load, busy and frame_cnt drop to 0 immediately with no frame_done.
  - After release, a new block is accepted and a full frame is sent.
- Back-to-back: blk_valid held high for 3 blocks with CNT_W=2 and frame_cnt preset by 1 prior frame:
  - 3 complete frames in order, no overlap; frame_cnt ends at 0 (wrap).

Source files
------------

// File: rtl/aes_tx_sequencer.sv
// rtl/aes_tx_sequencer.sv - streams one AES ciphertext block as a framed byte sequence into a UART transmitter
// Frame layout: optional SOF byte, 16 data bytes MSB first, optional CRC-8 (poly 0x07) trailer.

module aes_tx_sequencer #(
   parameter bit         SOF_EN   = 1'b1,
   parameter logic [7:0] SOF_BYTE = 8'hA5,
   parameter int         CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             blk_valid,
   output logic             blk_ready,
   input  logic [127:0]     blk_data,
   input  logic             crc_en,
   input  logic             tx_busy,
   output logic [7:0]       tx_data,
   output logic             tx_load,
   output logic             busy,
   output logic             frame_done,
   output logic [CNT_W-1:0] frame_cnt
);

   typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, DONE} state_t;

   localparam logic [4:0] FIRST_DATA = SOF_EN ? 5'd1 : 5'd0;

   state_t       state;
   logic [127:0] shreg;
   logic [7:0]   crc;
   logic         crc_en_q;
   logic [4:0]   idx;
   logic [4:0]   last_idx;

   logic [7:0]   src_top;
   logic [7:0]   crc_base;
   logic [7:0]   crc_upd;
   logic [7:0]   issue_byte;
   logic         is_sof;
   logic         is_crc;
   logic         is_data;

   function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      r = c ^ d;
      for (int i = 0; i < 8; i++) begin
         r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
      end
      return r;
   endfunction

   assign blk_ready = (state == IDLE) && !reset;
   assign last_idx  = FIRST_DATA + 5'd15 + {4'd0, crc_en_q};

   // In IDLE the first byte is taken straight from blk_data so it can load in the cycle after accept.
   always_comb begin
      src_top    = (state == IDLE) ? blk_data[127:120] : shreg[127:120];
      crc_base   = (state == IDLE) ? 8'h00 : crc;
      is_sof     = SOF_EN && (idx == 5'd0);
      is_crc     = (state != IDLE) && crc_en_q && (idx == last_idx);
      is_data    = !is_sof && !is_crc;
      crc_upd    = crc8_byte(crc_base, src_top);
      issue_byte = is_sof ? SOF_BYTE : (is_crc ? crc : src_top);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         shreg      <= '0;
         crc        <= 8'h00;
         crc_en_q   <= 1'b0;
         idx        <= 5'd0;
         tx_data    <= 8'h00;
         tx_load    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         tx_load    <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (blk_valid) begin
                  crc_en_q <= crc_en;
                  idx      <= 5'd0;
                  busy     <= 1'b1;
                  if (!tx_busy) begin
                     tx_load <= 1'b1;
                     tx_data <= issue_byte;
                     shreg   <= is_data ? {blk_data[119:0], 8'h00} : blk_data;
                     crc     <= is_data ? crc_upd : 8'h00;
                     state   <= GUARD;
                  end else begin
                     shreg <= blk_data;
                     crc   <= 8'h00;
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (!tx_busy) begin
                  tx_load <= 1'b1;
                  tx_data <= issue_byte;
                  if (is_data) begin
                     shreg <= {shreg[119:0], 8'h00};
                     crc   <= crc_upd;
                  end
                  state <= GUARD;
               end
            end
            // The UART raises busy one cycle after load, so its level here is meaningless.
            GUARD: state <= WAIT;
            WAIT: begin
               if (!tx_busy) begin
                  if (idx == last_idx) begin
                     idx        <= 5'd0;
                     frame_done <= 1'b1;
                     frame_cnt  <= frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                     state      <= DONE;
                  end else begin
                     idx   <= idx + 5'd1;
                     state <= ISSUE;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_tx_sequencer.sv
// tb/tb_aes_tx_sequencer.sv - self-checking bench for aes_tx_sequencer with a frame-level model and UART stub
`timescale 1ns/1ps

module tb_aes_tx_sequencer;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         blk_valid = 1'b0;
   logic         crc_en = 1'b0;
   logic         force_busy = 1'b0;
   logic [127:0] blk_data = '0;
   logic         blk_ready, tx_load, busy, frame_done, tx_busy;
   logic [7:0]   tx_data;
   logic [1:0]   frame_cnt;

   int uart_cnt = 0;
   int uart_len = 10;
   int loads_seen = 0;
   int loads_taken = 0;

   int n_tests = 0;
   int n_fail = 0;

   logic [7:0] exp_q[$];
   logic [7:0] log_q[$];
   int         model_cnt = 0;
   int         frames_done = 0;
   int         cyc = 0;
   int         last_load_cyc = -100;
   bit         acc_pend = 0;
   bit         done_prev = 0;
   bit         prev_busy_in = 0;
   logic [7:0] last_byte = 8'h00;

   logic [127:0] bx [3] = '{128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0,
                            128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF,
                            128'h8000000000000000000000000000FF01};

   assign tx_busy = force_busy | (uart_cnt != 0);

   always #5 clk = ~clk;

   aes_tx_sequencer #(
      .SOF_EN   (1'b1),
      .SOF_BYTE (8'hA5),
      .CNT_W    (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .blk_valid  (blk_valid),
      .blk_ready  (blk_ready),
      .blk_data   (blk_data),
      .crc_en     (crc_en),
      .tx_busy    (tx_busy),
      .tx_data    (tx_data),
      .tx_load    (tx_load),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bit-serial polynomial division over the 128 data bits.
   function automatic logic [7:0] model_crc(input logic [127:0] d);
      logic [7:0] c;
      logic       fb;
      c = 8'h00;
      for (int b = 127; b >= 0; b--) begin
         fb = c[7] ^ d[b];
         c  = {c[6:0], 1'b0};
         if (fb) c = c ^ 8'h07;
      end
      return c;
   endfunction

   // UART stub: busy for uart_len cycles starting the cycle after each load.
   always @(posedge clk) begin
      #1;
      if (uart_cnt > 0) uart_cnt--;
      if (loads_seen != loads_taken) begin
         loads_taken = loads_seen;
         uart_cnt    = uart_len;
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         chk("reset_tx_load", tx_load, 0);
         chk("reset_busy", busy, 0);
         chk("reset_frame_done", frame_done, 0);
         chk("reset_frame_cnt", frame_cnt, 0);
         chk("reset_blk_ready", blk_ready, 0);
         chk("reset_tx_data", tx_data, 0);
         exp_q.delete();
         model_cnt = 0;
         acc_pend  = 0;
         done_prev = 0;
         last_byte = 8'h00;
      end else begin
         if (acc_pend) begin
            chk("accept_busy", busy, 1);
            chk("accept_ready", blk_ready, 0);
            if (!prev_busy_in) chk("first_load_latency", tx_load, 1);
            acc_pend = 0;
         end
         if (done_prev) begin
            chk("ready_after_done", blk_ready, 1);
            done_prev = 0;
         end
         if (tx_load) begin
            loads_seen++;
            chk("load_needs_idle_uart", prev_busy_in, 0);
            chk("load_spacing", (cyc - last_load_cyc) >= 3, 1);
            last_load_cyc = cyc;
            log_q.push_back(tx_data);
            chk("load_within_frame", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               last_byte = exp_q.pop_front();
               chk("tx_data", tx_data, last_byte);
            end
         end else begin
            chk("tx_data_hold", tx_data, last_byte);
         end
         if (frame_done) begin
            frames_done++;
            chk("frame_complete", exp_q.size(), 0);
            model_cnt = (model_cnt + 1) % 4;
            done_prev = 1;
         end
         chk("frame_cnt", frame_cnt, model_cnt);
         chk("ready_vs_busy", blk_ready, !busy);
         if (blk_valid && blk_ready) begin
            chk("accept_only_when_idle", exp_q.size(), 0);
            exp_q.push_back(8'hA5);
            for (int i = 15; i >= 0; i--) exp_q.push_back(blk_data[i*8 +: 8]);
            if (crc_en) exp_q.push_back(model_crc(blk_data));
            acc_pend = 1;
         end
      end
      prev_busy_in = tx_busy;
   end

   task automatic wait_accept(input int budget);
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(blk_valid && blk_ready) && t < budget);
      chk("accept_timeout", blk_valid && blk_ready, 1);
   endtask

   task automatic wait_done(input int budget);
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!frame_done && t < budget);
      chk("frame_done_timeout", frame_done, 1);
      #1;
   endtask

   task automatic send_block(input logic [127:0] d, input logic c);
      log_q.delete();
      @(posedge clk);
      #1;
      blk_data  = d;
      crc_en    = c;
      blk_valid = 1'b1;
      wait_accept(200);
      @(posedge clk);
      #1;
      blk_valid = 1'b0;
      crc_en    = ~c;
   endtask

   initial begin
      int base;
      int t;

      chk("pin_crc_zero", model_crc(128'h0), 8'h00);
      chk("pin_crc_one", model_crc(128'h1), 8'h07);

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", blk_ready, 1);

      // All-zero block with CRC trailer.
      uart_len = 10;
      send_block(128'h0, 1'b1);
      wait_done(2000);
      chk("a_len", log_q.size(), 18);
      chk("a_sof", log_q[0], 8'hA5);
      for (int i = 1; i < 18; i++) chk("a_byte", log_q[i], 8'h00);
      chk("a_cnt", frame_cnt, 1);

      // Counting bytes, no trailer.
      send_block(128'h0102030405060708090A0B0C0D0E0F10, 1'b0);
      wait_done(2000);
      chk("b_len", log_q.size(), 17);
      chk("b_sof", log_q[0], 8'hA5);
      for (int i = 1; i < 17; i++) chk("b_byte", log_q[i], i);
      @(negedge clk);
      chk("b_ready_return", blk_ready, 1);
      chk("b_cnt", frame_cnt, 2);

      // Single low bit gives CRC 0x07.
      send_block(128'h1, 1'b1);
      wait_done(2000);
      chk("c_len", log_q.size(), 18);
      chk("c_last_data", log_q[16], 8'h01);
      chk("c_crc", log_q[17], 8'h07);
      chk("c_cnt", frame_cnt, 3);

      // Reset while the 5th data byte is being loaded.
      uart_len = 4;
      send_block(128'h00112233445566778899AABBCCDDEEFF, 1'b1);
      t = 0;
      do begin
         @(negedge clk);
         #1;
         t++;
      end while (log_q.size() < 6 && t < 500);
      chk("d_reach_fifth", log_q.size(), 6);
      chk("d_load_high", tx_load, 1);
      base = frames_done;
      reset = 1'b1;
      #1;
      chk("d_async_tx_load", tx_load, 0);
      chk("d_async_busy", busy, 0);
      chk("d_async_cnt", frame_cnt, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (30) @(negedge clk);
      chk("d_no_frame_done", frames_done - base, 0);

      // UART held busy at accept, then a busy glitch during GUARD.
      uart_len = 0;
      log_q.delete();
      @(posedge clk);
      #1;
      force_busy = 1'b1;
      blk_data   = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
      crc_en     = 1'b1;
      blk_valid  = 1'b1;
      wait_accept(50);
      @(posedge clk);
      #1 blk_valid = 1'b0;
      repeat (50) @(negedge clk);
      @(posedge clk);
      #1;
      chk("e_no_load_while_busy", log_q.size(), 0);
      force_busy = 1'b0;
      @(negedge clk);
      chk("e_load_not_same_cycle", tx_load, 0);
      @(posedge clk);
      #1 force_busy = 1'b1;
      @(negedge clk);
      chk("e_load_after_busy_falls", tx_load, 1);
      @(posedge clk);
      #1 force_busy = 1'b0;
      @(negedge clk);
      chk("e_wait_cycle", tx_load, 0);
      @(negedge clk);
      chk("e_issue_cycle", tx_load, 0);
      @(negedge clk);
      chk("e_guard_glitch_ignored", tx_load, 1);
      wait_done(500);
      chk("e_len", log_q.size(), 18);
      chk("e_cnt", frame_cnt, 1);

      // Three back-to-back blocks with blk_valid held; counter wraps to 0.
      uart_len = 2;
      base = frames_done;
      @(posedge clk);
      #1;
      blk_data  = bx[0];
      crc_en    = 1'b1;
      blk_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_accept(1000);
         @(posedge clk);
         #1;
         if (i < 2) begin
            blk_data = bx[i+1];
            crc_en   = (i == 0) ? 1'b0 : 1'b1;
         end else begin
            blk_valid = 1'b0;
         end
      end
      t = 0;
      while (frames_done < base + 3 && t < 1000) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("f_frames", frames_done - base, 3);
      chk("f_cnt_wrap", frame_cnt, 0);
      repeat (5) @(negedge clk);
      chk("f_idle_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

endmodule
